// File: rtl/if_id_hazard_stage.sv
// if_id_hazard_stage: IF/ID register with load-use stall, ID/EX bubble and branch/jump flush
module if_id_hazard_stage #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_plus4_i,
  input  logic [31:0]      instr_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_plus4_o,
  output logic             valid_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             bubble_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic valid_q, valid_d, take;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    hazard_o = valid_q & id_ex_memread_i & (id_ex_rt_i != 5'd0) &
               (id_ex_rt_i == instr_q[25:21] | id_ex_rt_i == instr_q[20:16]);
    take     = valid_q & (branch_taken_i | jump_i) & ~hazard_o;
    instr_d  = hazard_o ? instr_q : take ? NOP_INSTR : instr_i;
    pc_d     = hazard_o ? pc_q : pc_plus4_i;
    valid_d  = hazard_o ? valid_q : ~take;
    stall_d  = (hazard_o && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d  = (take && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign instr_o     = instr_q;
  assign pc_plus4_o  = pc_q;
  assign valid_o     = valid_q;
  assign pc_write_o  = ~hazard_o;
  assign bubble_o    = hazard_o;
  assign pc_src_o    = take;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule

// File: tb/tb_if_id_hazard_stage.sv
// tb_if_id_hazard_stage: directed vectors with hand-computed expectations
module tb_if_id_hazard_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc4_i = '0, instr_i = '0;
  logic memread = 1'b0, br = 1'b0, jmp = 1'b0;
  logic [4:0] rt_i = '0;
  logic [31:0] instr_o, pc4_o;
  logic valid_o, pc_write_o, pc_src_o, bubble_o, hazard_o;
  logic [15:0] stall_cnt, flush_cnt;
  int vectors = 0, errs = 0;

  if_id_hazard_stage dut (
    .clk_i(clk), .rst_i(rst), .pc_plus4_i(pc4_i), .instr_i(instr_i),
    .id_ex_memread_i(memread), .id_ex_rt_i(rt_i), .branch_taken_i(br), .jump_i(jmp),
    .instr_o(instr_o), .pc_plus4_o(pc4_o), .valid_o(valid_o), .pc_write_o(pc_write_o),
    .pc_src_o(pc_src_o), .bubble_o(bubble_o), .hazard_o(hazard_o),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic hz, input logic src);
    chk({tag, "_hazard"}, {31'd0, hazard_o}, {31'd0, hz});
    chk({tag, "_bubble"}, {31'd0, bubble_o}, {31'd0, hz});
    chk({tag, "_pc_write"}, {31'd0, pc_write_o}, {31'd0, ~hz});
    chk({tag, "_pc_src"}, {31'd0, pc_src_o}, {31'd0, src});
  endtask

  task automatic regs(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic v, input logic [15:0] sc, input logic [15:0] fc);
    chk({tag, "_instr"}, instr_o, ins);
    chk({tag, "_pc4"}, pc4_o, pc);
    chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, {16'd0, sc});
    chk({tag, "_flush_cnt"}, {16'd0, flush_cnt}, {16'd0, fc});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    regs("reset", 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    ctl("reset", 1'b0, 1'b0);
    rst = 1'b0;
    instr_i = 32'h0044_1820; pc4_i = 32'h8;
    tick;
    regs("load1", 32'h0044_1820, 32'h8, 1'b1, 16'd0, 16'd0);
    // load into $2 sits in EX while add reads $2 as rs
    memread = 1'b1; rt_i = 5'd2; instr_i = 32'h1111_1111; pc4_i = 32'hC;
    #1 ctl("loaduse", 1'b1, 1'b0);
    tick;
    regs("stall", 32'h0044_1820, 32'h8, 1'b1, 16'd1, 16'd0);
    memread = 1'b0; instr_i = 32'h0005_1820; pc4_i = 32'h10;
    #1 ctl("after_stall", 1'b0, 1'b0);
    tick;
    regs("resume", 32'h0005_1820, 32'h10, 1'b1, 16'd1, 16'd0);
    memread = 1'b1; rt_i = 5'd0; instr_i = 32'h0044_1820; pc4_i = 32'h14;
    #1 ctl("zero_reg", 1'b0, 1'b0);
    tick;
    regs("zero_reg", 32'h0044_1820, 32'h14, 1'b1, 16'd1, 16'd0);
    memread = 1'b0; br = 1'b1; instr_i = 32'hDEAD_BEEF; pc4_i = 32'h10;
    #1 ctl("branch", 1'b0, 1'b1);
    tick;
    regs("flush", 32'h0, 32'h10, 1'b0, 16'd1, 16'd1);
    memread = 1'b1; rt_i = 5'd2; jmp = 1'b1; instr_i = 32'h0044_1820; pc4_i = 32'h14;
    #1 ctl("flushed_slot", 1'b0, 1'b0);
    memread = 1'b0;
    tick;
    regs("post_flush", 32'h0044_1820, 32'h14, 1'b1, 16'd1, 16'd1);
    br = 1'b0; jmp = 1'b1; memread = 1'b1; rt_i = 5'd4; instr_i = 32'h2222_2222; pc4_i = 32'h18;
    #1 ctl("hz_vs_jump", 1'b1, 1'b0);
    tick;
    regs("hz_vs_jump", 32'h0044_1820, 32'h14, 1'b1, 16'd2, 16'd1);
    jmp = 1'b0; memread = 1'b0; instr_i = 32'h8C22_0004; pc4_i = 32'h1C;
    tick;
    regs("pre_reset", 32'h8C22_0004, 32'h1C, 1'b1, 16'd2, 16'd1);
    rst = 1'b1;
    #1;
    regs("mid_reset", 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    ctl("mid_reset", 1'b0, 1'b0);
    rst = 1'b0; instr_i = 32'h0044_1820; pc4_i = 32'h20;
    tick;
    regs("post_reset", 32'h0044_1820, 32'h20, 1'b1, 16'd0, 16'd0);
    memread = 1'b1; rt_i = 5'd2;
    repeat (65536) @(posedge clk);
    #1;
    regs("saturate", 32'h0044_1820, 32'h20, 1'b1, 16'hFFFF, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    regs("sat_hold", 32'h0044_1820, 32'h20, 1'b1, 16'hFFFF, 16'd0);
    ctl("sat_hold", 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
